recepcao_movimentos: RTL and testbench
======================================

RECEPCAO_MOVIMENTOS -- requirements
Module: recepcao_movimentos

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 434, clock cycles per serial bit (50 MHz / 115200).
REQ-002 SHALL have parameter MAX_MOV, default 32, move buffer depth.
REQ-003 SHALL have parameter TIMEOUT_BITS, default 20, idle bit-times before abort (used only under REQ-030).
REQ-004 SHALL have port clock  in  1  single system clock; all logic on rising edge.
REQ-005 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-006 SHALL have port iniciar  in  1  one-cycle pulse: clear buffer, arm reception.
REQ-007 SHALL have port rx_serial  in  1  UART line from host, 8N1, LSB first, idle high.
REQ-008 SHALL have port zera_movimento  in  1  reset read index to 0.
REQ-009 SHALL have port conta_movimento  in  1  advance read index by 1.
REQ-010 SHALL have port movimento  out  4  move code at read index.
REQ-011 SHALL have port movimentos_recebidos  out  1  level: complete valid sequence stored.
REQ-012 SHALL have port fim_movimento  out  1  read index == stored count.
REQ-013 SHALL have port num_movimentos  out  6  number of moves stored.
REQ-014 SHALL have port erro_recepcao  out  1  level: reception aborted.
REQ-015 SHALL have port db_estado  out  3  current FSM state encoding.

Function
REQ-016 SHALL decode bytes: 0x00-0x0B valid move codes (U,U',D,D',L,L',R,R',F,F',B,B'), 0xFF terminator, all others invalid.
REQ-017 SHALL run FSM states ocioso(0), espera(1), recebe(2), armazena(3), fim(4), erro(5).
REQ-018 SHALL move ocioso->espera on iniciar, clearing count, read index, movimentos_recebidos, erro_recepcao.
REQ-019 SHALL move espera->recebe on a falling edge of rx_serial; start bit confirmed low at CLKS_PER_BIT/2, else back to espera.
REQ-020 SHALL sample each data bit and the stop bit at bit centre; stop bit low -> erro.
REQ-021 SHALL, in armazena (one cycle), write valid code at address num_movimentos, increment count, return to espera.
REQ-022 SHALL go to fim on 0xFF with count>=1, asserting movimentos_recebidos next cycle; 0xFF with count 0 -> erro.
REQ-023 SHALL go to erro on invalid byte or on a valid move when count == MAX_MOV (buffer full); byte not stored.
REQ-024 SHALL hold fim/erro until iniciar (re-arm) or reset; iniciar in any state restarts at REQ-018.
REQ-025 SHALL present movimento combinationally from buffer at read index (0 latency); conta_movimento saturates at count; zera_movimento has priority over conta_movimento in the same cycle.
REQ-026 SHALL ignore rx_serial activity while in ocioso, fim or erro.

Reset
REQ-027 SHALL on reset enter ocioso; movimento=0, movimentos_recebidos=0, fim_movimento=1 (0==0), num_movimentos=0, erro_recepcao=0, db_estado=0.
REQ-028 SHALL abort a byte in progress when reset asserts mid-frame; no partial write.
REQ-029 SHALL not require buffer contents cleared on reset; reads beyond count are don't-care.

Configuration
REQ-030 SHALL, with RECEPCAO_TIMEOUT_EN defined, go to erro when espera persists TIMEOUT_BITS*CLKS_PER_BIT cycles after at least one stored byte; without it, espera waits indefinitely.

Structure
REQ-031 SHALL place move-code constants, terminator 0xFF and state encodings in shared package rubiks_polibot_pkg.
REQ-032 SHALL implement bit timing/shift in sub-module rx_serial_8N1 (outputs dado[7:0], pronto pulse, erro_stop).

Verification
REQ-033 SHALL check (CLKS_PER_BIT=4) iniciar, bytes 0x00,0x05,0x0B,0xFF -> num_movimentos=3, movimentos_recebidos=1, reads 0,5,11 then fim_movimento=1.
REQ-034 SHALL check byte 0x3C after one valid move -> erro_recepcao=1, num_movimentos=1, movimentos_recebidos=0.
REQ-035 SHALL check MAX_MOV=4, five valid moves -> erro at fifth, num_movimentos=4.
REQ-036 SHALL check stop bit forced low on second byte -> erro_recepcao=1; iniciar then clean 0x02,0xFF -> num_movimentos=1, movimento=2.
REQ-037 SHALL check reset asserted mid-byte -> db_estado=0, num_movimentos=0, no write; 1-cycle low glitch in espera -> no byte.
REQ-038 SHALL check with RECEPCAO_TIMEOUT_EN, TIMEOUT_BITS=20: one move then idle 80 cycles -> erro_recepcao=1.

Source files
------------

// File: rtl/rubiks_polibot_pkg.sv
// Shared constants for the Rubik move receiver: move codes, terminator,
// controller and serial-receiver state encodings, code validity helper.
package rubiks_polibot_pkg;

    localparam logic [7:0] MOV_U      = 8'h00;
    localparam logic [7:0] MOV_UL     = 8'h01;
    localparam logic [7:0] MOV_D      = 8'h02;
    localparam logic [7:0] MOV_DL     = 8'h03;
    localparam logic [7:0] MOV_L      = 8'h04;
    localparam logic [7:0] MOV_LL     = 8'h05;
    localparam logic [7:0] MOV_R      = 8'h06;
    localparam logic [7:0] MOV_RL     = 8'h07;
    localparam logic [7:0] MOV_F      = 8'h08;
    localparam logic [7:0] MOV_FL     = 8'h09;
    localparam logic [7:0] MOV_B      = 8'h0A;
    localparam logic [7:0] MOV_BL     = 8'h0B;
    localparam logic [7:0] TERMINADOR = 8'hFF;

    typedef enum logic [2:0] {
        OCIOSO   = 3'd0,
        ESPERA   = 3'd1,
        RECEBE   = 3'd2,
        ARMAZENA = 3'd3,
        FIM      = 3'd4,
        ERRO     = 3'd5
    } estado_t;

    typedef enum logic [1:0] {
        R_LIVRE  = 2'd0,
        R_INICIO = 2'd1,
        R_DADOS  = 2'd2,
        R_PARADA = 2'd3
    } rx_estado_t;

    function automatic logic codigo_valido(input logic [7:0] b);
        return b <= MOV_BL;
    endfunction

endpackage

// File: rtl/rx_serial_8N1.sv
// 8N1 UART receiver, LSB first, idle high, sampled at bit centres.
// Ports: clock, reset (sync, active high), habilita (receiver enabled),
//        rx_serial (line), dado (last good byte), pronto (1-cycle pulse),
//        erro_stop (1-cycle pulse, stop bit low), ocupado (frame in progress).
module rx_serial_8N1
    import rubiks_polibot_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       habilita,
    input  logic       rx_serial,
    output logic [7:0] dado,
    output logic       pronto,
    output logic       erro_stop,
    output logic       ocupado
);

    localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] FIM_BIT  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] MEIO_BIT = CW'(CLKS_PER_BIT / 2 - 1);

    rx_estado_t      est;
    logic [2:0]      amostra;
    logic [CW-1:0]   cnt;
    logic [2:0]      idx;
    logic [7:0]      desloc;
    logic            linha;
    logic            anterior;

    // Two-stage synchroniser plus one extra stage for falling-edge detection.
    always_ff @(posedge clock) begin
        if (reset)
            amostra <= 3'b111;
        else
            amostra <= {amostra[1:0], rx_serial};
    end

    assign linha    = amostra[1];
    assign anterior = amostra[2];
    assign ocupado  = (est != R_LIVRE);

    always_ff @(posedge clock) begin
        if (reset) begin
            est       <= R_LIVRE;
            cnt       <= '0;
            idx       <= '0;
            desloc    <= '0;
            dado      <= '0;
            pronto    <= 1'b0;
            erro_stop <= 1'b0;
        end else begin
            pronto    <= 1'b0;
            erro_stop <= 1'b0;
            if (!habilita) begin
                est <= R_LIVRE;
            end else begin
                unique case (est)
                    R_LIVRE: begin
                        if (anterior && !linha) begin
                            est <= R_INICIO;
                            cnt <= '0;
                        end
                    end
                    R_INICIO: begin
                        // A start bit that is high again at mid-bit was a glitch.
                        if (cnt == MEIO_BIT) begin
                            cnt <= '0;
                            idx <= '0;
                            est <= linha ? R_LIVRE : R_DADOS;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    R_DADOS: begin
                        if (cnt == FIM_BIT) begin
                            cnt    <= '0;
                            desloc <= {linha, desloc[7:1]};
                            if (idx == 3'd7)
                                est <= R_PARADA;
                            else
                                idx <= idx + 1'b1;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    R_PARADA: begin
                        if (cnt == FIM_BIT) begin
                            est <= R_LIVRE;
                            if (linha) begin
                                dado   <= desloc;
                                pronto <= 1'b1;
                            end else begin
                                erro_stop <= 1'b1;
                            end
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    default: est <= R_LIVRE;
                endcase
            end
        end
    end

endmodule

// File: rtl/recepcao_movimentos.sv
// Receives a sequence of Rubik move codes over UART into a buffer, ended by 0xFF.
// Ports: clock, reset, iniciar (arm), rx_serial, zera/conta_movimento (read index),
//        movimento, movimentos_recebidos, fim_movimento, num_movimentos,
//        erro_recepcao, db_estado. Macro RECEPCAO_TIMEOUT_EN enables idle abort.
module recepcao_movimentos
    import rubiks_polibot_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434,
    parameter int MAX_MOV      = 32,
    parameter int TIMEOUT_BITS = 20
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       iniciar,
    input  logic       rx_serial,
    input  logic       zera_movimento,
    input  logic       conta_movimento,
    output logic [3:0] movimento,
    output logic       movimentos_recebidos,
    output logic       fim_movimento,
    output logic [5:0] num_movimentos,
    output logic       erro_recepcao,
    output logic [2:0] db_estado
);

    localparam int AW = (MAX_MOV > 1) ? $clog2(MAX_MOV) : 1;
    localparam logic [5:0] MAX_C = 6'(MAX_MOV);

    estado_t    estado;
    logic [5:0] contagem;
    logic [5:0] indice;
    logic [3:0] mem [MAX_MOV];
    logic [7:0] dado;
    logic       pronto;
    logic       erro_stop;
    logic       ocupado;
    logic       rx_habilita;
    logic       rx_reset;
    logic       estouro;

    assign rx_habilita = (estado == ESPERA) || (estado == RECEBE) ||
                         (estado == ARMAZENA);
    // iniciar discards any frame in flight.
    assign rx_reset = reset | iniciar;

    rx_serial_8N1 #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_rx (
        .clock    (clock),
        .reset    (rx_reset),
        .habilita (rx_habilita),
        .rx_serial(rx_serial),
        .dado     (dado),
        .pronto   (pronto),
        .erro_stop(erro_stop),
        .ocupado  (ocupado)
    );

`ifdef RECEPCAO_TIMEOUT_EN
    localparam int TO_CYC = TIMEOUT_BITS * CLKS_PER_BIT;
    localparam int TW = $clog2(TO_CYC + 1);

    logic [TW-1:0] ociosidade;

    // Idle time counts only while waiting for a byte after the first stored one.
    always_ff @(posedge clock) begin
        if (reset || estado != ESPERA || contagem == 6'd0)
            ociosidade <= '0;
        else if (!estouro)
            ociosidade <= ociosidade + 1'b1;
    end

    assign estouro = (ociosidade == TW'(TO_CYC));
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT_BITS != 0);
    assign estouro = 1'b0;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            estado               <= OCIOSO;
            contagem             <= '0;
            indice               <= '0;
            movimentos_recebidos <= 1'b0;
            erro_recepcao        <= 1'b0;
        end else if (iniciar) begin
            estado               <= ESPERA;
            contagem             <= '0;
            indice               <= '0;
            movimentos_recebidos <= 1'b0;
            erro_recepcao        <= 1'b0;
        end else begin
            if (zera_movimento)
                indice <= '0;
            else if (conta_movimento && indice != contagem)
                indice <= indice + 1'b1;

            unique case (estado)
                OCIOSO, FIM, ERRO: ;
                ESPERA: begin
                    if (estouro) begin
                        estado        <= ERRO;
                        erro_recepcao <= 1'b1;
                    end else if (ocupado) begin
                        estado <= RECEBE;
                    end
                end
                RECEBE: begin
                    if (erro_stop) begin
                        estado        <= ERRO;
                        erro_recepcao <= 1'b1;
                    end else if (pronto) begin
                        if (dado == TERMINADOR && contagem != 6'd0) begin
                            estado               <= FIM;
                            movimentos_recebidos <= 1'b1;
                        end else if (codigo_valido(dado) && contagem != MAX_C) begin
                            estado <= ARMAZENA;
                        end else begin
                            estado        <= ERRO;
                            erro_recepcao <= 1'b1;
                        end
                    end else if (!ocupado) begin
                        estado <= ESPERA;
                    end
                end
                ARMAZENA: begin
                    contagem <= contagem + 1'b1;
                    estado   <= ESPERA;
                end
                default: estado <= OCIOSO;
            endcase
        end
    end

    // Buffer has no reset; entries beyond contagem are never presented.
    always_ff @(posedge clock) begin
        if (!reset && !iniciar && estado == ARMAZENA)
            mem[contagem[AW-1:0]] <= dado[3:0];
    end

    assign movimento      = (indice < contagem) ? mem[indice[AW-1:0]] : 4'd0;
    assign fim_movimento  = (indice == contagem);
    assign num_movimentos = contagem;
    assign db_estado      = estado;

endmodule

// File: tb/tb_recepcao_movimentos.sv
// Randomised self-checking bench for recepcao_movimentos against a
// sequence-level reference model of the byte protocol.
module tb_recepcao_movimentos;

    localparam int CPB  = 4;
    localparam int MAXM = 4;

    logic       clock = 1'b0;
    logic       reset;
    logic       iniciar;
    logic       rx_serial;
    logic       zera_movimento;
    logic       conta_movimento;
    logic [3:0] movimento;
    logic       movimentos_recebidos;
    logic       fim_movimento;
    logic [5:0] num_movimentos;
    logic       erro_recepcao;
    logic [2:0] db_estado;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] seq_b[$];
    bit         seq_ok[$];
    int         exp_codes[$];
    int         exp_st;

    always #5 clock = ~clock;

    recepcao_movimentos #(
        .CLKS_PER_BIT(CPB),
        .MAX_MOV     (MAXM),
        .TIMEOUT_BITS(20)
    ) dut (
        .clock               (clock),
        .reset               (reset),
        .iniciar             (iniciar),
        .rx_serial           (rx_serial),
        .zera_movimento      (zera_movimento),
        .conta_movimento     (conta_movimento),
        .movimento           (movimento),
        .movimentos_recebidos(movimentos_recebidos),
        .fim_movimento       (fim_movimento),
        .num_movimentos      (num_movimentos),
        .erro_recepcao       (erro_recepcao),
        .db_estado           (db_estado)
    );

    task automatic check(input string tag, input int obs, input int exp);
        n_tests++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic pulse_iniciar();
        iniciar = 1'b1;
        @(negedge clock);
        iniciar = 1'b0;
        @(negedge clock);
    endtask

    task automatic send_byte(input logic [7:0] b, input bit ok);
        rx_serial = 1'b0;
        repeat (CPB) @(negedge clock);
        for (int i = 0; i < 8; i++) begin
            rx_serial = b[i];
            repeat (CPB) @(negedge clock);
        end
        rx_serial = ok;
        repeat (CPB) @(negedge clock);
        rx_serial = 1'b1;
        repeat ($urandom_range(1, 4)) @(negedge clock);
    endtask

    // Protocol outcome of a byte sequence: stored codes and final state.
    task automatic model();
        exp_codes.delete();
        exp_st = 1;
        foreach (seq_b[i]) begin
            if (exp_st != 1) break;
            if (!seq_ok[i])
                exp_st = 5;
            else if (seq_b[i] == 8'hFF)
                exp_st = (exp_codes.size() > 0) ? 4 : 5;
            else if (seq_b[i] <= 8'h0B) begin
                if (exp_codes.size() == MAXM)
                    exp_st = 5;
                else
                    exp_codes.push_back(int'(seq_b[i]));
            end else
                exp_st = 5;
        end
    endtask

    task automatic read_back();
        int n;
        n = exp_codes.size();
        zera_movimento = 1'b1;
        @(negedge clock);
        zera_movimento = 1'b0;
        for (int i = 0; i < n; i++) begin
            check("movimento", movimento, exp_codes[i]);
            check("fim_early", fim_movimento, 0);
            conta_movimento = 1'b1;
            @(negedge clock);
            conta_movimento = 1'b0;
        end
        check("fim_end", fim_movimento, 1);
        conta_movimento = 1'b1;
        @(negedge clock);
        conta_movimento = 1'b0;
        check("fim_sat", fim_movimento, 1);
        if (n > 0) begin
            zera_movimento  = 1'b1;
            conta_movimento = 1'b1;
            @(negedge clock);
            zera_movimento  = 1'b0;
            conta_movimento = 1'b0;
            check("zera_prio_mov", movimento, exp_codes[0]);
            check("zera_prio_fim", fim_movimento, 0);
        end
    endtask

    task automatic run_seq(input bit arm);
        if (arm) pulse_iniciar();
        foreach (seq_b[i]) send_byte(seq_b[i], seq_ok[i]);
        repeat (12) @(negedge clock);
        model();
        check("num", num_movimentos, exp_codes.size());
        check("estado", db_estado, exp_st);
        check("recebidos", movimentos_recebidos, (exp_st == 4) ? 1 : 0);
        check("erro", erro_recepcao, (exp_st == 5) ? 1 : 0);
        read_back();
    endtask

    initial begin
        reset = 1'b1;
        iniciar = 1'b0;
        rx_serial = 1'b1;
        zera_movimento = 1'b0;
        conta_movimento = 1'b0;
        repeat (3) @(negedge clock);
        check("rst_estado", db_estado, 0);
        check("rst_num", num_movimentos, 0);
        check("rst_recebidos", movimentos_recebidos, 0);
        check("rst_erro", erro_recepcao, 0);
        check("rst_fim", fim_movimento, 1);
        check("rst_mov", movimento, 0);
        reset = 1'b0;
        @(negedge clock);

        // Line activity in ocioso is ignored.
        send_byte(8'h03, 1'b1);
        repeat (8) @(negedge clock);
        check("ocioso_estado", db_estado, 0);
        check("ocioso_num", num_movimentos, 0);

        // Basic sequence, invalid byte, buffer overflow.
        seq_b = '{8'h00, 8'h05, 8'h0B, 8'hFF};
        seq_ok = '{1, 1, 1, 1};
        run_seq(1);
        seq_b = '{8'h04, 8'h3C, 8'hFF};
        seq_ok = '{1, 1, 1};
        run_seq(1);
        seq_b = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
        seq_ok = '{1, 1, 1, 1, 1};
        run_seq(1);
        seq_b = '{8'hFF};
        seq_ok = '{1};
        run_seq(1);

        // Bad stop bit, then re-arm and a clean sequence.
        seq_b = '{8'h06, 8'h07, 8'hFF};
        seq_ok = '{1, 0, 1};
        run_seq(1);
        seq_b = '{8'h02, 8'hFF};
        seq_ok = '{1, 1};
        run_seq(1);

        // Reset in the middle of a frame.
        pulse_iniciar();
        send_byte(8'h01, 1'b1);
        rx_serial = 1'b0;
        repeat (CPB) @(negedge clock);
        rx_serial = 1'b1;
        repeat (2 * CPB) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        rx_serial = 1'b1;
        @(negedge clock);
        check("midrst_estado", db_estado, 0);
        check("midrst_num", num_movimentos, 0);
        check("midrst_fim", fim_movimento, 1);
        check("midrst_mov", movimento, 0);

        // One-cycle glitch while waiting produces no byte.
        pulse_iniciar();
        rx_serial = 1'b0;
        @(negedge clock);
        rx_serial = 1'b1;
        repeat (20) @(negedge clock);
        check("glitch_estado", db_estado, 1);
        check("glitch_num", num_movimentos, 0);
        seq_b = '{8'h09, 8'hFF};
        seq_ok = '{1, 1};
        run_seq(0);

        // Idle after one stored move.
        pulse_iniciar();
        send_byte(8'h08, 1'b1);
        repeat (100) @(negedge clock);
`ifdef RECEPCAO_TIMEOUT_EN
        check("timeout_erro", erro_recepcao, 1);
        check("timeout_estado", db_estado, 5);
`else
        check("notimeout_erro", erro_recepcao, 0);
        check("notimeout_estado", db_estado, 1);
`endif
        check("timeout_num", num_movimentos, 1);

        // Random sequences.
        for (int t = 0; t < 40; t++) begin
            int len;
            seq_b.delete();
            seq_ok.delete();
            len = $urandom_range(1, 6);
            for (int k = 0; k < len; k++) begin
                int r;
                logic [7:0] b;
                r = $urandom_range(0, 99);
                if (r < 55)
                    b = 8'($urandom_range(0, 11));
                else if (r < 72)
                    b = 8'hFF;
                else
                    b = 8'($urandom_range(12, 254));
                seq_b.push_back(b);
                seq_ok.push_back($urandom_range(0, 99) >= 8);
            end
            run_seq(1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
